alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- instr  input  8  instruction byte: [7:4] ALU op code, [3] A-select, [2] B-select, [1:0] class
- instr_valid  input  1  instr holds a valid instruction
- instr_ready  output  1  block accepts instr this cycle
- s_af  output  4  ALU op code to ALU
- s3  output  1  ALU A-operand select (1 = RN, 0 = R0)
- s4  output  1  ALU B-operand select (1 = OR2, 0 = RN)
- cin  output  1  ALU carry in
- flag_array  input  4  ALU flags: [3] odd parity, [2] positive, [1] carry, [0] zero
- r0_we  output  1  write ALU result to R0
- rn_we  output  1  write ALU result to RN
- flags  output  4  latched flag register, same bit order as flag_array
- done_valid  output  1  instruction complete, response pending
- done_ready  input  1  consumer takes response
- branch_taken  output  1  branch condition result, valid with done_valid
- op_count  output  16  count of completed instructions
REQ-002 SHALL have no parameters; all widths are fixed.

Function
REQ-003 SHALL implement the states IDLE, EXEC and RESP.
REQ-004 IDLE: instr_ready=1; on instr_valid, SHALL latch instr and move to EXEC.
REQ-005 EXEC: lasts exactly one cycle and moves to RESP; s_af/s3/s4 SHALL be driven from the latched instr; cin=flags[1].
REQ-006 RESP: done_valid=1; SHALL return to IDLE on done_ready, otherwise hold with all outputs stable.
REQ-007 Outside EXEC, s_af=4'h0, s3=0, s4=0 and cin=0.
REQ-008 Class 00: r0_we=1 during EXEC; class 01: rn_we=1 during EXEC; classes 10 and 11: no write enable.
REQ-009 Classes 00, 01 and 10: flags SHALL load flag_array at the end of EXEC; class 11 leaves flags unchanged.
REQ-010 r0_we and rn_we SHALL never both be 1, and each SHALL be 1 for at most one cycle per instruction.
REQ-011 op_count SHALL increment on the RESP-to-IDLE handshake and wrap 16'hFFFF to 0.
REQ-012 Minimum throughput is one instruction per 3 cycles (done_ready held 1); instr_ready=0 in EXEC and RESP.
REQ-013 branch_taken SHALL be 0 for classes 00, 01 and 10.

Reset
REQ-014 With reset=1 at a clock edge, the block SHALL enter IDLE; flags=0, op_count=0, done_valid=0, branch_taken=0, r0_we=0, rn_we=0, s_af=0, s3=0, s4=0, cin=0.
REQ-015 Reset during EXEC or RESP SHALL abort the instruction: no write enable, no flag load, no op_count increment.
REQ-016 instr_valid SHALL be ignored in the cycle reset is high.

Configuration
REQ-017 Macro RNBIP_COND_BRANCH_EN, defined: class 11 is a conditional branch.
- instr[7:6] selects a flags bit by index.
- instr[5]=1 tests for set, 0 tests for clear.
- branch_taken is computed from flags during EXEC and registered into RESP.
- s_af is forced to 0 in EXEC.
REQ-018 RNBIP_COND_BRANCH_EN undefined: class 11 SHALL be a NOP that still passes IDLE-EXEC-RESP and increments op_count; branch_taken=0.

Structure
REQ-019 A shared package SHALL hold the 16 ALU op code constants, class codes, the state enum and the flag bit indices (ZERO=0, CARRY=1, POS=2, PAR=3).
REQ-020 Branch evaluation SHALL be the sub-module alu_cond_eval, combinational, instantiated only under RNBIP_COND_BRANCH_EN.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset then instr=8'h80 (ADD, class 00), flag_array=4'b0110 -> EXEC: s_af=8, r0_we=1 for one cycle; RESP: flags=4'b0110, done_valid=1; op_count=1 after handshake.
- flags[1]=1, instr=8'hA9 (ADD_ABC, s3=1, class 01) -> EXEC: cin=1, s3=1, rn_we=1, r0_we=0.
- Class 10 compare, done_ready low for 5 cycles -> done_valid, flags and branch_taken stable, instr_ready=0, no write enables.
- Macro on, flags=4'b0001, instr=8'h23 (bit 0, test set) -> branch_taken=1, flags unchanged; instr=8'h03 -> branch_taken=0.
- Reset asserted during EXEC of a class 00 instruction -> r0_we=0 next cycle, IDLE, flags=0, op_count unchanged at 0.
- 65536 back-to-back instructions with done_ready=1 -> op_count wraps to 0, one instruction per 3 cycles.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_pkg
// Shared definitions for the ALU sequencing controller:
//   - 16 ALU op codes (instr[7:4])
//   - instruction class codes (instr[1:0])
//   - controller state enum
//   - flag bit indices for flag_array / flags
// No ports (package).
// -----------------------------------------------------------------------------
package alu_seq_ctrl_pkg;

    // ALU op codes, driven on s_af during EXEC
    localparam logic [3:0] OP_PASS_A  = 4'h0;
    localparam logic [3:0] OP_PASS_B  = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_NOT_A   = 4'h5;
    localparam logic [3:0] OP_SHL     = 4'h6;
    localparam logic [3:0] OP_SHR     = 4'h7;
    localparam logic [3:0] OP_ADD     = 4'h8;
    localparam logic [3:0] OP_ADDC    = 4'h9;
    localparam logic [3:0] OP_ADD_ABC = 4'hA;
    localparam logic [3:0] OP_SUB     = 4'hB;
    localparam logic [3:0] OP_SUBB    = 4'hC;
    localparam logic [3:0] OP_INC     = 4'hD;
    localparam logic [3:0] OP_DEC     = 4'hE;
    localparam logic [3:0] OP_CMP     = 4'hF;

    // Instruction classes
    localparam logic [1:0] CLS_WR_R0 = 2'b00;  // result -> R0
    localparam logic [1:0] CLS_WR_RN = 2'b01;  // result -> RN
    localparam logic [1:0] CLS_CMP   = 2'b10;  // flags only
    localparam logic [1:0] CLS_BR    = 2'b11;  // branch (or NOP)

    // Flag bit indices
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_POS   = 2;
    localparam int FLAG_PAR   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Every class except the branch/NOP class captures the ALU flags.
    function automatic logic cls_loads_flags(input logic [1:0] cls);
        return cls != CLS_BR;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_cond.sv
// -----------------------------------------------------------------------------
// alu_cond_eval
// Combinational branch condition: selects one flag bit by index and tests it
// for set (i_test_set=1) or clear (i_test_set=0).
// Ports:
//   i_flags    [3:0] latched flag register
//   i_bit_sel  [1:0] flag bit index (instr[7:6])
//   i_test_set       1 = taken when bit set, 0 = taken when bit clear
//   o_taken          condition result
// Only instantiated when RNBIP_COND_BRANCH_EN is defined.
// -----------------------------------------------------------------------------
module alu_cond_eval (
    input  logic [3:0] i_flags,
    input  logic [1:0] i_bit_sel,
    input  logic       i_test_set,
    output logic       o_taken
);

    logic w_bit;

    assign w_bit   = i_flags[i_bit_sel];
    assign o_taken = (w_bit == i_test_set);

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Three-state sequencer (IDLE -> EXEC -> RESP) that decodes one instruction
// byte, steers the ALU for one cycle, captures flags and hands a response to a
// consumer with a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr[7:0]          [7:4] op, [3] A-sel, [2] B-sel, [1:0] class
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   s_af, s3, s4, cin   ALU controls, non-zero only during EXEC
//   flag_array[3:0]     ALU flags, sampled at the end of EXEC
//   r0_we, rn_we        register write enables, one EXEC cycle at most
//   flags[3:0]          latched flag register
//   done_valid/ready    response handshake (valid in RESP)
//   branch_taken        branch result, qualified by done_valid
//   op_count[15:0]      completed instruction count, wraps
//
// Build option: define RNBIP_COND_BRANCH_EN to make class 11 a conditional
// branch (instr[7:6] flag index, instr[5] test polarity). Without it class 11
// is a NOP that still walks all three states.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  s_af,
    output logic        s3,
    output logic        s4,
    output logic        cin,
    input  logic [3:0]  flag_array,
    output logic        r0_we,
    output logic        rn_we,
    output logic [3:0]  flags,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        branch_taken,
    output logic [15:0] op_count
);

    state_t      r_state;
    logic [1:0]  r_cls;
    logic        r_instr_ready;
    logic [3:0]  r_s_af;
    logic        r_s3;
    logic        r_s4;
    logic        r_cin;
    logic        r_r0_we;
    logic        r_rn_we;
    logic [3:0]  r_flags;
    logic        r_done_valid;
    logic        r_branch_taken;
    logic [15:0] r_op_count;
    logic        w_branch_taken;
    logic [3:0]  w_exec_op;

`ifdef RNBIP_COND_BRANCH_EN
    logic [2:0]  r_cond;      // instr[7:5]: flag index + test polarity
    logic        w_cond_taken;

    alu_cond_eval u_cond_eval (
        .i_flags    (r_flags),
        .i_bit_sel  (r_cond[2:1]),
        .i_test_set (r_cond[0]),
        .o_taken    (w_cond_taken)
    );

    // flags still hold the pre-instruction value during EXEC; class 11
    // never reloads them, so the test sees the state the program branched on.
    assign w_branch_taken = (r_cls == CLS_BR) && w_cond_taken;
    // The upper nibble of a branch carries condition fields, not an op.
    assign w_exec_op      = (instr[1:0] == CLS_BR) ? OP_PASS_A : instr[7:4];
`else
    assign w_branch_taken = 1'b0;
    assign w_exec_op      = instr[7:4];
`endif

    // ALU controls are loaded on the IDLE->EXEC edge so that they are
    // registered and valid for exactly the EXEC cycle, then cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cls          <= CLS_WR_R0;
            r_instr_ready  <= 1'b1;
            r_s_af         <= 4'h0;
            r_s3           <= 1'b0;
            r_s4           <= 1'b0;
            r_cin          <= 1'b0;
            r_r0_we        <= 1'b0;
            r_rn_we        <= 1'b0;
            r_flags        <= 4'h0;
            r_done_valid   <= 1'b0;
            r_branch_taken <= 1'b0;
            r_op_count     <= 16'h0000;
`ifdef RNBIP_COND_BRANCH_EN
            r_cond         <= 3'b000;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_cls         <= instr[1:0];
                        r_s_af        <= w_exec_op;
                        r_s3          <= instr[3];
                        r_s4          <= instr[2];
                        r_cin         <= r_flags[FLAG_CARRY];
                        r_r0_we       <= (instr[1:0] == CLS_WR_R0);
                        r_rn_we       <= (instr[1:0] == CLS_WR_RN);
                        r_instr_ready <= 1'b0;
`ifdef RNBIP_COND_BRANCH_EN
                        r_cond        <= instr[7:5];
`endif
                        r_state       <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_s_af         <= 4'h0;
                    r_s3           <= 1'b0;
                    r_s4           <= 1'b0;
                    r_cin          <= 1'b0;
                    r_r0_we        <= 1'b0;
                    r_rn_we        <= 1'b0;
                    if (cls_loads_flags(r_cls)) begin
                        r_flags <= flag_array;
                    end
                    r_branch_taken <= w_branch_taken;
                    r_done_valid   <= 1'b1;
                    r_state        <= ST_RESP;
                end

                ST_RESP: begin
                    // Everything holds until the consumer takes the response.
                    if (done_ready) begin
                        r_done_valid   <= 1'b0;
                        r_branch_taken <= 1'b0;
                        r_op_count     <= r_op_count + 16'h0001;
                        r_instr_ready  <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_ready <= 1'b1;
                    r_done_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready  = r_instr_ready;
    assign s_af         = r_s_af;
    assign s3           = r_s3;
    assign s4           = r_s4;
    assign cin          = r_cin;
    assign r0_we        = r_r0_we;
    assign rn_we        = r_rn_we;
    assign flags        = r_flags;
    assign done_valid   = r_done_valid;
    assign branch_taken = r_branch_taken;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl. A small reference model (flag register
// and completion counter, plus per-instruction expected outputs derived from
// the instruction byte) predicts every observed value. Honors
// RNBIP_COND_BRANCH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  s_af;
    logic        s3, s4, cin;
    logic [3:0]  flag_array;
    logic        r0_we, rn_we;
    logic [3:0]  flags;
    logic        done_valid;
    logic        done_ready;
    logic        branch_taken;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .s_af         (s_af),
        .s3           (s3),
        .s4           (s4),
        .cin          (cin),
        .flag_array   (flag_array),
        .r0_we        (r0_we),
        .rn_we        (rn_we),
        .flags        (flags),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .branch_taken (branch_taken),
        .op_count     (op_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;

    // observations from one transaction
    logic [3:0]  x_saf;                    // EXEC cycle
    logic        x_s3, x_s4, x_cin, x_r0, x_rn, x_rdy;
    logic        y_dv, y_br, y_rdy, y_we, y_alu; // first RESP cycle
    logic [3:0]  y_flags;
    logic        y_stable;                 // RESP outputs unchanged while stalled
    logic [15:0] z_cnt;                    // back in IDLE
    logic        z_dv, z_rdy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected ALU op on s_af during EXEC.
    function automatic logic [3:0] exp_saf(input logic [7:0] ins);
`ifdef RNBIP_COND_BRANCH_EN
        if (ins[1:0] == 2'b11) return 4'h0;
`endif
        return ins[7:4];
    endfunction

    // Expected branch outcome given the flags held before the instruction.
    function automatic logic exp_br(input logic [7:0] ins, input logic [3:0] fl);
`ifdef RNBIP_COND_BRANCH_EN
        logic [1:0] idx;
        idx = ins[7:6];
        if (ins[1:0] == 2'b11) return fl[idx] == ins[5];
`endif
        return 1'b0;
    endfunction

    // Drive one instruction from IDLE through handshake; records observations
    // only (callers compare). Model is updated afterwards.
    task automatic run_instr(input logic [7:0] ins, input logic [3:0] fa, input int hold);
        instr       = ins;
        instr_valid = 1'b1;
        done_ready  = 1'b0;
        flag_array  = 4'($urandom);
        tick();                                   // EXEC
        instr_valid = 1'b0;
        instr       = 8'($urandom);
        x_saf = s_af; x_s3 = s3; x_s4 = s4; x_cin = cin;
        x_r0 = r0_we; x_rn = rn_we; x_rdy = instr_ready;
        flag_array  = fa;
        tick();                                   // RESP
        y_dv = done_valid; y_br = branch_taken; y_rdy = instr_ready;
        y_we = r0_we | rn_we; y_alu = |{s_af, s3, s4, cin}; y_flags = flags;
        y_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            flag_array  = 4'($urandom);
            instr_valid = 1'($urandom);
            tick();
            if (done_valid !== y_dv || flags !== y_flags || branch_taken !== y_br ||
                instr_ready !== y_rdy || (r0_we | rn_we) !== 1'b0 || |{s_af, s3, s4, cin} !== 1'b0)
                y_stable = 1'b0;
        end
        instr_valid = 1'b0;
        done_ready  = 1'b1;
        tick();                                   // IDLE
        done_ready  = 1'b0;
        z_cnt = op_count; z_dv = done_valid; z_rdy = instr_ready;
        if (ins[1:0] != 2'b11) m_flags = fa;
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr = 8'h80; instr_valid = 1'b1; done_ready = 1'b0;
        flag_array = 4'hF;
        tick(); tick();
        n_cmp++; if ({r0_we, rn_we, done_valid, branch_taken} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0000", {r0_we, rn_we, done_valid, branch_taken}); end
        n_cmp++; if ({s_af, s3, s4, cin} !== 7'h00) begin
            n_bad++; $display("FAIL reset_alu: got %h want 00", {s_af, s3, s4, cin}); end
        n_cmp++; if (flags !== 4'h0 || op_count !== 16'h0) begin
            n_bad++; $display("FAIL reset_regs: flags %h cnt %h want 0 0", flags, op_count); end
        n_cmp++; if (instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        reset = 1'b0; instr_valid = 1'b0;
        tick();
        n_cmp++; if (instr_ready !== 1'b1 || r0_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: ready %b r0_we %b want 1 0", instr_ready, r0_we); end
        m_flags = 4'h0; m_cnt = 16'h0;
    endtask

    task automatic test_add_r0();
        run_instr(8'h80, 4'b0110, 0);
        n_cmp++; if ({x_saf, x_r0, x_rn, x_rdy} !== {4'h8, 3'b100}) begin
            n_bad++; $display("FAIL add_exec: got %h want %h", {x_saf, x_r0, x_rn, x_rdy}, {4'h8, 3'b100}); end
        n_cmp++; if (y_we !== 1'b0) begin
            n_bad++; $display("FAIL add_we_one_cycle: got %b want 0", y_we); end
        n_cmp++; if (y_flags !== 4'b0110 || y_dv !== 1'b1) begin
            n_bad++; $display("FAIL add_resp: flags %b dv %b want 0110 1", y_flags, y_dv); end
        n_cmp++; if (z_cnt !== 16'd1 || z_dv !== 1'b0 || z_rdy !== 1'b1) begin
            n_bad++; $display("FAIL add_done: cnt %0d dv %b rdy %b want 1 0 1", z_cnt, z_dv, z_rdy); end
    endtask

    task automatic test_addc_rn();
        logic exp_cin;
        exp_cin = m_flags[1];
        run_instr(8'hA9, 4'($urandom), 0);
        n_cmp++; if ({x_cin, x_s3, x_s4, x_rn, x_r0, x_saf} !== {exp_cin, 4'b1010, 4'hA}) begin
            n_bad++; $display("FAIL addc_exec: got %h want %h", {x_cin, x_s3, x_s4, x_rn, x_r0, x_saf},
                              {exp_cin, 4'b1010, 4'hA}); end
        n_cmp++; if (x_cin !== 1'b1) begin
            n_bad++; $display("FAIL addc_cin: got %b want 1", x_cin); end
    endtask

    task automatic test_stall();
        logic [15:0] c0;
        c0 = m_cnt;
        run_instr(8'hF6, 4'b1001, 5);
        n_cmp++; if (y_stable !== 1'b1) begin
            n_bad++; $display("FAIL stall_stable: got %b want 1", y_stable); end
        n_cmp++; if ({y_dv, y_rdy, y_we, y_br, x_r0, x_rn} !== 6'b100000) begin
            n_bad++; $display("FAIL stall_ctl: got %b want 100000", {y_dv, y_rdy, y_we, y_br, x_r0, x_rn}); end
        n_cmp++; if (y_flags !== 4'b1001 || z_cnt !== c0 + 16'd1) begin
            n_bad++; $display("FAIL stall_flags_cnt: flags %b cnt %0d want 1001 %0d", y_flags, z_cnt, c0 + 16'd1); end
    endtask

    task automatic test_class11();
`ifdef RNBIP_COND_BRANCH_EN
        run_instr(8'h02, 4'b0001, 0);
        run_instr(8'h23, 4'b1110, 0);
        n_cmp++; if ({y_br, y_flags, x_saf} !== {1'b1, 4'b0001, 4'h0}) begin
            n_bad++; $display("FAIL br_set: got %h want %h", {y_br, y_flags, x_saf}, {1'b1, 4'b0001, 4'h0}); end
        run_instr(8'h03, 4'b1110, 0);
        n_cmp++; if ({y_br, y_flags} !== {1'b0, 4'b0001}) begin
            n_bad++; $display("FAIL br_clr: got %h want %h", {y_br, y_flags}, {1'b0, 4'b0001}); end
`else
        logic [3:0]  f0;
        logic [15:0] c0;
        f0 = m_flags; c0 = m_cnt;
        run_instr(8'hC7, ~f0, 0);
        n_cmp++; if ({y_br, y_flags, x_r0, x_rn, x_saf} !== {1'b0, f0, 2'b00, 4'hC}) begin
            n_bad++; $display("FAIL nop_resp: got %h want %h", {y_br, y_flags, x_r0, x_rn, x_saf},
                              {1'b0, f0, 2'b00, 4'hC}); end
        n_cmp++; if (z_cnt !== c0 + 16'd1) begin
            n_bad++; $display("FAIL nop_cnt: got %0d want %0d", z_cnt, c0 + 16'd1); end
`endif
    endtask

    task automatic test_random();
        logic [7:0]  ins;
        logic [3:0]  fa, ef;
        logic [9:0]  ex;
        logic        eb;
        int          bad_e = 0, bad_r = 0, bad_c = 0;
        for (int n = 0; n < 300; n++) begin
            ins = 8'($urandom);
            fa  = 4'($urandom);
            ex  = {exp_saf(ins), ins[3], ins[2], m_flags[1], ins[1:0] == 2'b00, ins[1:0] == 2'b01, 1'b0};
            eb  = exp_br(ins, m_flags);
            ef  = (ins[1:0] == 2'b11) ? m_flags : fa;
            run_instr(ins, fa, int'($urandom_range(0, 3)));
            n_cmp++; if ({x_saf, x_s3, x_s4, x_cin, x_r0, x_rn, x_rdy} !== ex) begin
                n_bad++; bad_e++;
                if (bad_e < 5) $display("FAIL rand_exec ins=%h: got %h want %h", ins,
                                        {x_saf, x_s3, x_s4, x_cin, x_r0, x_rn, x_rdy}, ex); end
            n_cmp++; if ({y_dv, y_flags, y_br, y_we, y_alu, y_rdy, y_stable} !== {1'b1, ef, eb, 3'b000, 1'b1}) begin
                n_bad++; bad_r++;
                if (bad_r < 5) $display("FAIL rand_resp ins=%h: got %h want %h", ins,
                                        {y_dv, y_flags, y_br, y_we, y_alu, y_rdy, y_stable},
                                        {1'b1, ef, eb, 3'b000, 1'b1}); end
            n_cmp++; if (z_cnt !== m_cnt || z_dv !== 1'b0) begin
                n_bad++; bad_c++;
                if (bad_c < 5) $display("FAIL rand_cnt: got %0d dv %b want %0d 0", z_cnt, z_dv, m_cnt); end
        end
    endtask

    task automatic test_reset_exec();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        m_flags = 4'h0; m_cnt = 16'h0;
        instr = 8'h80; instr_valid = 1'b1; done_ready = 1'b1; flag_array = 4'hF;
        tick();                                    // EXEC
        instr_valid = 1'b0;
        n_cmp++; if (r0_we !== 1'b1) begin
            n_bad++; $display("FAIL rexec_pre: r0_we %b want 1", r0_we); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({r0_we, done_valid, instr_ready, flags, op_count} !== {3'b001, 4'h0, 16'h0}) begin
            n_bad++; $display("FAIL rexec_abort: got %h want %h", {r0_we, done_valid, instr_ready, flags, op_count},
                              {3'b001, 4'h0, 16'h0}); end
        reset = 1'b0;
        tick();
        n_cmp++; if ({done_valid, flags, op_count} !== 21'h0) begin
            n_bad++; $display("FAIL rexec_after: got %h want 0", {done_valid, flags, op_count}); end
        done_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic tput_ok = 1'b1;
        logic [15:0] kk;
        instr = 8'h4E; instr_valid = 1'b1; done_ready = 1'b1; flag_array = 4'h5;
        for (int k = 1; k <= 65536; k++) begin
            tick(); tick(); tick();
            kk = 16'(k);
            if (op_count !== kk || instr_ready !== 1'b1) tput_ok = 1'b0;
            if (k == 65535) begin
                n_cmp++; if (op_count !== 16'hFFFF) begin
                    n_bad++; $display("FAIL b2b_max: got %h want ffff", op_count); end
            end
        end
        instr_valid = 1'b0; done_ready = 1'b0;
        n_cmp++; if (op_count !== 16'h0000) begin
            n_bad++; $display("FAIL b2b_wrap: got %h want 0000", op_count); end
        n_cmp++; if (tput_ok !== 1'b1) begin
            n_bad++; $display("FAIL b2b_rate: got %b want 1", tput_ok); end
    endtask

    initial begin
        test_reset();
        test_add_r0();
        test_addc_rn();
        test_stall();
        test_class11();
        test_random();
        test_reset_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
